// File: rtl/mem_stage.sv
// mem_stage: memory stage of a five-stage RISC-V pipeline.
//
// Holds the EX/MEM pipeline register and runs loads and stores against a
// variable-latency data memory through a req/ack handshake. It builds store byte
// lanes, sign/zero-extends load data and flags misaligned or malformed accesses.
// It drives the MEM/WB register, exports M-stage forwarding values, and stalls
// the front of the pipeline while an access is outstanding.
//
// Ports
//   clk, rst_n          pipeline clock (rising edge), async active-low reset
//   *_e                 execute-stage control and data (EX/MEM register inputs)
//   dmem_req/we/addr/be/wdata  data memory request side (held until ack)
//   dmem_ack/rdata      data memory completion; rdata valid with ack
//   alu_result_m, rd_m, reg_write_m  forwarding values from the M register
//   mem_stall           freeze F/D/E and the EX/MEM register
//   *_w, misalign_w     MEM/WB register to writeback
//   stall_cnt           saturating count of stalled cycles
module mem_stage #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     reg_write_e,
  input  logic                     mem_write_e,
  input  logic [1:0]               res_src_e,
  input  logic [2:0]               funct3_e,
  input  logic [DATA_WIDTH-1:0]    alu_result_e,
  input  logic [DATA_WIDTH-1:0]    write_data_e,
  input  logic [4:0]               rd_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [ADDRESS_WIDTH-1:0] dmem_addr,
  output logic [3:0]               dmem_be,
  output logic [DATA_WIDTH-1:0]    dmem_wdata,
  input  logic                     dmem_ack,
  input  logic [DATA_WIDTH-1:0]    dmem_rdata,
  output logic [DATA_WIDTH-1:0]    alu_result_m,
  output logic [4:0]               rd_m,
  output logic                     reg_write_m,
  output logic                     mem_stall,
  output logic                     reg_write_w,
  output logic [1:0]               res_src_w,
  output logic [4:0]               rd_w,
  output logic [DATA_WIDTH-1:0]    alu_result_w,
  output logic [DATA_WIDTH-1:0]    read_data_w,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_w,
  output logic                     misalign_w,
  output logic [15:0]              stall_cnt
);

  localparam logic [1:0] ResLoad = 2'b01;

  // funct3 encodings for loads (stores share the low two bits for size)
  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  // Misaligned halfword/word or reserved size encoding.
  function automatic logic f_access_err(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic err;
    case (funct3)
      3'b001, 3'b101:         err = addr_lo[0];
      3'b010:                 err = (addr_lo != 2'b00);
      3'b011, 3'b110, 3'b111: err = 1'b1;
      default:                err = 1'b0;
    endcase
    return err;
  endfunction

  // EX/MEM register
  logic                     r_reg_write_m;
  logic                     r_mem_write_m;
  logic [1:0]               r_res_src_m;
  logic [2:0]               r_funct3_m;
  logic [DATA_WIDTH-1:0]    r_alu_result_m;
  logic [DATA_WIDTH-1:0]    r_write_data_m;
  logic [4:0]               r_rd_m;
  logic [ADDRESS_WIDTH-1:0] r_pc_plus4_m;

  // MEM/WB register
  logic                     r_reg_write_w;
  logic [1:0]               r_res_src_w;
  logic [4:0]               r_rd_w;
  logic [DATA_WIDTH-1:0]    r_alu_result_w;
  logic [DATA_WIDTH-1:0]    r_read_data_w;
  logic [ADDRESS_WIDTH-1:0] r_pc_plus4_w;
  logic                     r_misalign_w;

  state_e                   r_state;
  logic [15:0]              r_stall_cnt;

  logic                     w_stall;
  logic                     w_mem_op_e;
  logic                     w_start_e;
  logic                     w_load_m;
  logic                     w_mem_op_m;
  logic                     w_err_m;
  logic [3:0]               w_be;
  logic [DATA_WIDTH-1:0]    w_wdata;
  logic [7:0]               w_byte;
  logic [15:0]              w_half;
  logic [DATA_WIDTH-1:0]    w_load_data;

  assign w_mem_op_e = (res_src_e == ResLoad) | mem_write_e;
  // An access starts only for a well-formed memory op; faulting ops never request.
  assign w_start_e  = w_mem_op_e & ~f_access_err(funct3_e, alu_result_e[1:0]);

  assign w_load_m   = (r_res_src_m == ResLoad);
  assign w_mem_op_m = w_load_m | r_mem_write_m;
  assign w_err_m    = w_mem_op_m & f_access_err(r_funct3_m, r_alu_result_m[1:0]);

  assign w_stall    = (r_state == StBusy) & ~dmem_ack;

  // BUSY exactly when M holds a valid, error-free memory op, so every M-load
  // decides the next state and a stall simply holds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else if (!w_stall) begin
      r_state <= w_start_e ? StBusy : StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_write_m  <= 1'b0;
      r_mem_write_m  <= 1'b0;
      r_res_src_m    <= '0;
      r_funct3_m     <= '0;
      r_alu_result_m <= '0;
      r_write_data_m <= '0;
      r_rd_m         <= '0;
      r_pc_plus4_m   <= '0;
    end else if (!w_stall) begin
      r_reg_write_m  <= reg_write_e;
      r_mem_write_m  <= mem_write_e;
      r_res_src_m    <= res_src_e;
      r_funct3_m     <= funct3_e;
      r_alu_result_m <= alu_result_e;
      r_write_data_m <= write_data_e;
      r_rd_m         <= rd_e;
      r_pc_plus4_m   <= pc_plus4_e;
    end
  end

  // Store lane generation; loads always read the full word.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_write_data_m;
    if (r_mem_write_m) begin
      case (r_funct3_m[1:0])
        2'b00: begin
          w_be    = 4'b0001 << r_alu_result_m[1:0];
          w_wdata = {(DATA_WIDTH / 8){r_write_data_m[7:0]}};
        end
        2'b01: begin
          w_be    = r_alu_result_m[1] ? 4'b1100 : 4'b0011;
          w_wdata = {(DATA_WIDTH / 16){r_write_data_m[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Load lane select and extension.
  always_comb begin
    case (r_alu_result_m[1:0])
      2'b00:   w_byte = dmem_rdata[7:0];
      2'b01:   w_byte = dmem_rdata[15:8];
      2'b10:   w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_alu_result_m[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_funct3_m)
      F3Lb:    w_load_data = {{(DATA_WIDTH - 8){w_byte[7]}}, w_byte};
      F3Lh:    w_load_data = {{(DATA_WIDTH - 16){w_half[15]}}, w_half};
      F3Lbu:   w_load_data = {{(DATA_WIDTH - 8){1'b0}}, w_byte};
      F3Lhu:   w_load_data = {{(DATA_WIDTH - 16){1'b0}}, w_half};
      default: w_load_data = dmem_rdata;
    endcase
  end

  // MEM/WB: a stall inserts a bubble; otherwise capture M (ack edge for memory ops).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_write_w  <= 1'b0;
      r_res_src_w    <= '0;
      r_rd_w         <= '0;
      r_alu_result_w <= '0;
      r_read_data_w  <= '0;
      r_pc_plus4_w   <= '0;
      r_misalign_w   <= 1'b0;
    end else if (w_stall) begin
      r_reg_write_w  <= 1'b0;
      r_res_src_w    <= '0;
      r_rd_w         <= '0;
      r_alu_result_w <= '0;
      r_read_data_w  <= '0;
      r_pc_plus4_w   <= '0;
      r_misalign_w   <= 1'b0;
    end else begin
      r_reg_write_w  <= r_reg_write_m & ~w_err_m;
      r_res_src_w    <= r_res_src_m;
      r_rd_w         <= r_rd_m;
      r_alu_result_w <= r_alu_result_m;
      r_read_data_w  <= (w_load_m & ~w_err_m) ? w_load_data : '0;
      r_pc_plus4_w   <= r_pc_plus4_m;
      r_misalign_w   <= w_err_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  // Request side is driven only while BUSY so idle outputs read as zero; the
  // M register is frozen during the access, keeping these stable until ack.
  assign dmem_req     = (r_state == StBusy);
  assign dmem_we      = dmem_req & r_mem_write_m;
  assign dmem_addr    = dmem_req ? {r_alu_result_m[ADDRESS_WIDTH-1:2], 2'b00} : '0;
  assign dmem_be      = dmem_req ? w_be : '0;
  assign dmem_wdata   = (dmem_req & r_mem_write_m) ? w_wdata : '0;

  assign mem_stall    = w_stall;
  assign alu_result_m = r_alu_result_m;
  assign rd_m         = r_rd_m;
  assign reg_write_m  = r_reg_write_m;

  assign reg_write_w  = r_reg_write_w;
  assign res_src_w    = r_res_src_w;
  assign rd_w         = r_rd_w;
  assign alu_result_w = r_alu_result_w;
  assign read_data_w  = r_read_data_w;
  assign pc_plus4_w   = r_pc_plus4_w;
  assign misalign_w   = r_misalign_w;
  assign stall_cnt    = r_stall_cnt;

endmodule
